// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline buffer.
//   DefaultDataW : default payload width
//   StallCntW    : width of the stall performance counter
//   occ_e        : occupancy encodings (OCC_EMPTY, OCC_ONE, OCC_FULL)
//   occ_count()  : folds the two slot valid bits into an occupancy code
package pipe_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned StallCntW    = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_count(input logic main_valid, input logic skid_valid);
    logic [1:0] sum;
    sum = {1'b0, main_valid} + {1'b0, skid_valid};
    return occ_e'(sum);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline buffer: a data register plus valid bit.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (valid=0, data=RST_DATA)
//   load_i   capture data_i and set valid
//   clear_i  drop valid; data register keeps its value
//   data_i   payload to capture
//   valid_o  slot holds a live entry
//   data_o   stored payload
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = DefaultDataW,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Clear beats load so a squash never resurrects an entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe_buf.sv
// EX->MEM pipeline buffer: two-entry skid buffer with valid/ready handshake,
// synchronous flush and registered occupancy. up_ready comes straight from the
// skid valid register, so there is no combinational path from dn_ready to EX.
// Optional stall performance counter enabled by macro EX_MEM_PIPE_BUF_PERF_EN.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset, highest priority
//   flush         squash all buffered entries at the edge
//   up_valid/up_ready/up_data   EX-side handshake and payload
//   dn_valid/dn_ready/dn_data   MEM-side handshake and payload (main slot)
//   occupancy     number of live entries (0..2), registered
//   stall_cycles  saturating count of dn_valid & !dn_ready cycles (0 if disabled)
module ex_mem_pipe_buf
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = DefaultDataW,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [DATA_W-1:0]    up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [DATA_W-1:0]    dn_data,
  output logic [1:0]           occupancy,
  output logic [StallCntW-1:0] stall_cycles
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              main_load, main_clr, skid_load, skid_clr;
  logic [DATA_W-1:0] main_data_d;
  logic              main_valid_d, skid_valid_d;
  logic              accept, drain;
  occ_e              occ_q, occ_d;

  assign accept = up_valid & ~skid_valid;
  assign drain  = main_valid & dn_ready;

  always_comb begin
    main_load   = 1'b0;
    main_clr    = 1'b0;
    skid_load   = 1'b0;
    skid_clr    = 1'b0;
    main_data_d = up_data;
    if (flush) begin
      // Same-cycle accept is dropped; a same-cycle drain is still seen by MEM.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (skid_valid) begin
      // up_ready is low here, so only the skid-to-main move can happen.
      if (drain) begin
        main_load   = 1'b1;
        main_data_d = skid_data;
        skid_clr    = 1'b1;
      end
    end else if (main_valid && !drain) begin
      if (accept) begin
        skid_load = 1'b1;
      end
    end else begin
      if (accept) begin
        main_load = 1'b1;
      end else if (drain) begin
        main_clr = 1'b1;
      end
    end
  end

  // Next valid bits, used only to keep occupancy registered and in step.
  always_comb begin
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (main_clr) begin
      main_valid_d = 1'b0;
    end else if (main_load) begin
      main_valid_d = 1'b1;
    end
    if (skid_clr) begin
      skid_valid_d = 1'b0;
    end else if (skid_load) begin
      skid_valid_d = 1'b1;
    end
    occ_d = occ_count(main_valid_d, skid_valid_d);
  end

  pipe_slot #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_main_slot (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (main_load),
    .clear_i (main_clr),
    .data_i  (main_data_d),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_slot #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_skid_slot (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .data_i  (up_data),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign up_ready  = ~skid_valid;
  assign dn_valid  = main_valid;
  assign dn_data   = main_data;
  assign occupancy = occ_q;

`ifdef EX_MEM_PIPE_BUF_PERF_EN
  logic [StallCntW-1:0] stall_q;

  // Saturating; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !dn_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// Bench for ex_mem_pipe_buf: a 16-bit and a 32-bit instance share one stimulus
// stream. A queue-style reference model per instance tracks the expected
// contents in arrival order; a negedge monitor compares every visible output.
module tb_ex_mem_pipe_buf;

`ifdef EX_MEM_PIPE_BUF_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam logic [15:0] Rst16 = 16'h00C3;
  localparam logic [31:0] Rst32 = 32'h0;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, dn_ready;
  logic [31:0] up_data;

  logic        ur16, dv16, ur32, dv32;
  logic [15:0] dd16, st16, st32;
  logic [31:0] dd32;
  logic [1:0]  oc16, oc32;

  always #5 clk = ~clk;

  ex_mem_pipe_buf #(
    .DATA_W   (16),
    .RST_DATA (Rst16)
  ) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .up_valid     (up_valid),
    .up_ready     (ur16),
    .up_data      (up_data[15:0]),
    .dn_valid     (dv16),
    .dn_ready     (dn_ready),
    .dn_data      (dd16),
    .occupancy    (oc16),
    .stall_cycles (st16)
  );

  ex_mem_pipe_buf #(
    .DATA_W   (32),
    .RST_DATA (Rst32)
  ) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .up_valid     (up_valid),
    .up_ready     (ur32),
    .up_data      (up_data),
    .dn_valid     (dv32),
    .dn_ready     (dn_ready),
    .dn_data      (dd32),
    .occupancy    (oc32),
    .stall_cycles (st32)
  );

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_data  [2];
  logic [1:0]  o_occ   [2];
  logic [15:0] o_stall [2];

  assign o_ready[0] = ur16;
  assign o_ready[1] = ur32;
  assign o_valid[0] = dv16;
  assign o_valid[1] = dv32;
  assign o_data[0]  = {16'h0, dd16};
  assign o_data[1]  = dd32;
  assign o_occ[0]   = oc16;
  assign o_occ[1]   = oc32;
  assign o_stall[0] = st16;
  assign o_stall[1] = st32;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t act=%h exp=%h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: ordered list of in-flight payloads (at most 2), stall count,
  // and whether the main data register still holds its reset value.
  logic [31:0] m_ent   [2][2];
  int          m_cnt   [2];
  int          m_stall [2];
  bit          m_clean [2];
  bit          known = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] mask, rstv, d;
      bit          acc;
      mask = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      rstv = (k == 0) ? {16'h0, Rst16} : Rst32;
      d    = up_data & mask;
      if (known) begin
        chk("dn_valid", k, {31'h0, o_valid[k]}, (m_cnt[k] != 0) ? 32'd1 : 32'd0);
        chk("up_ready", k, {31'h0, o_ready[k]}, (m_cnt[k] < 2) ? 32'd1 : 32'd0);
        chk("occupancy", k, {30'h0, o_occ[k]}, m_cnt[k]);
        if (m_cnt[k] > 0) chk("dn_data", k, o_data[k], m_ent[k][0]);
        else if (m_clean[k]) chk("dn_data_rst", k, o_data[k], rstv);
        chk("stall_cycles", k, {16'h0, o_stall[k]}, m_stall[k]);
        // Skid occupied implies main occupied.
        if (o_occ[k] == 2'd2) chk("skid_implies_main", k, {31'h0, o_valid[k]}, 32'd1);
      end
      if (rst) begin
        m_cnt[k]   = 0;
        m_stall[k] = 0;
        m_clean[k] = 1'b1;
      end else if (known) begin
        if (PerfEn && m_cnt[k] > 0 && !dn_ready && m_stall[k] < 65535) m_stall[k]++;
        acc = up_valid && (m_cnt[k] < 2);
        if (m_cnt[k] > 0 && dn_ready) begin
          m_ent[k][0] = m_ent[k][1];
          m_cnt[k]--;
        end
        if (flush) begin
          m_cnt[k] = 0;
        end else if (acc) begin
          m_ent[k][m_cnt[k]] = d;
          m_cnt[k]++;
          m_clean[k] = 1'b0;
        end
      end
    end
    if (rst) known = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    dn_ready = 1'b0;
    up_data  = '0;
    step(2);
    rst = 1'b0;

    // Flow-through 0..15 with MEM always ready.
    dn_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      up_valid = 1'b1;
      up_data  = i;
      step(1);
    end
    up_valid = 1'b0;
    step(2);

    // Backpressure: two entries pile up, then drain in order.
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 32'h0000_A5A5;
    step(1);
    up_data  = 32'h0000_5A5A;
    step(1);
    up_valid = 1'b0;
    step(3);
    dn_ready = 1'b1;
    step(3);

    // Flush while full with a simultaneous offered payload.
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 32'h0000_1111;
    step(1);
    up_data  = 32'h0000_2222;
    step(1);
    flush    = 1'b1;
    up_data  = 32'h0000_1234;
    step(1);
    flush    = 1'b0;
    up_valid = 1'b0;
    step(2);

    // Reset while full.
    up_valid = 1'b1;
    up_data  = 32'h0000_3333;
    step(1);
    up_data  = 32'h0000_4444;
    step(1);
    up_valid = 1'b0;
    rst      = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // Wide payloads with dn_ready toggling every cycle.
    up_valid = 1'b1;
    up_data  = 32'hDEAD_BEEF;
    dn_ready = 1'b0;
    step(1);
    up_data  = 32'hCAFE_F00D;
    dn_ready = 1'b1;
    step(1);
    up_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dn_ready = ~dn_ready;
      step(1);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      up_valid = 1'($urandom_range(0, 1));
      dn_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      up_data  = $urandom;
      step(1);
    end
    flush    = 1'b0;
    up_valid = 1'b0;

    // Stall counting: 7 stalled cycles, then long enough to saturate.
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 32'h0000_7777;
    step(1);
    up_valid = 1'b0;
    step(7);
    step(70000);
    dn_ready = 1'b1;
    step(3);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
